// File: rtl/rv_pkg.sv
// Shared RV32I/RV32E decode constants: opcodes, fn7 values and immediate formats.
package rv_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FN7_BASE = 7'b0000000;
    localparam logic [6:0] FN7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [XLEN-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [6:0]           opcode;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [2:0]           fn3;
    logic [6:0]           fn7;
    logic [XLEN-1:0]      imm;
    logic                 illegal;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, fn3, fn7, imm, illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, rs1, rs2, fn3, fn7, imm, illegal
    );
endinterface

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I/RV32E field, immediate and legality decoder.
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5,
    parameter bit          EN_SYSTEM = 1'b1
) (
    input  logic [ILEN-1:0]      inst,
    output logic [6:0]           opcode_c,
    output logic [RF_ADDR_W-1:0] rd_c,
    output logic [RF_ADDR_W-1:0] rs1_c,
    output logic [RF_ADDR_W-1:0] rs2_c,
    output logic [2:0]           fn3_c,
    output logic [6:0]           fn7_c,
    output logic [XLEN-1:0]      imm_c,
    output logic                 illegal_c
);
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               use_rd, use_rs1, use_rs2, use_fn3, use_fn7;
    logic               shamt;
    logic               bad;
    logic               rve_bad;
    imm_fmt_e           fmt;
    logic signed [31:0] imm32;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    // Per-opcode field usage and encoding checks
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_fn3 = 1'b0;
        use_fn7 = 1'b0;
        shamt   = 1'b0;
        bad     = 1'b0;
        fmt     = IMM_NONE;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1;
                fmt    = IMM_U;
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                fmt    = IMM_J;
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_fn3 = 1'b1;
                fmt     = IMM_I;
                bad     = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_fn3 = 1'b1;
                fmt     = IMM_B;
                bad     = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_fn3 = 1'b1;
                fmt     = IMM_I;
                bad     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_fn3 = 1'b1;
                fmt     = IMM_S;
                bad     = (f3 >= 3'b011);
            end
            OPC_OPIMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_fn3 = 1'b1;
                fmt     = IMM_I;
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    shamt   = 1'b1;
                    use_fn7 = 1'b1;
                    bad     = !((f7 == FN7_BASE) || ((f7 == FN7_ALT) && (f3 == 3'b101)));
                end
            end
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_fn3 = 1'b1;
                use_fn7 = 1'b1;
                bad     = !((f7 == FN7_BASE) ||
                            ((f7 == FN7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_FENCE, OPC_SYSTEM: begin
                if (EN_SYSTEM) begin
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    use_fn3 = 1'b1;
                    fmt     = IMM_I;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) begin
            bad = 1'b1;
        end
    end

    // RV32E only has x0..x15: bit 4 of any used index is an illegal encoding
    assign rve_bad = (RF_ADDR_W == 4) &&
                     ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]));

    assign illegal_c = bad || rve_bad;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        if (shamt) begin
            imm32 = {27'b0, inst[24:20]};
        end
    end

    // Unused or illegal fields are forced to zero; opcode always passes through
    always_comb begin
        opcode_c = opc;
        rd_c     = '0;
        rs1_c    = '0;
        rs2_c    = '0;
        fn3_c    = '0;
        fn7_c    = '0;
        imm_c    = '0;
        if (!illegal_c) begin
            if (use_rd)  rd_c  = RF_ADDR_W'(inst[11:7]);
            if (use_rs1) rs1_c = RF_ADDR_W'(inst[19:15]);
            if (use_rs2) rs2_c = RF_ADDR_W'(inst[24:20]);
            if (use_fn3) fn3_c = f3;
            if (use_fn7) fn7_c = f7;
            imm_c = XLEN'(imm32);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one pipeline register with valid/ready flow control and flush.
module decode_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5,
    parameter bit          EN_SYSTEM = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);
    logic [6:0]           opcode_c;
    logic [RF_ADDR_W-1:0] rd_c, rs1_c, rs2_c;
    logic [2:0]           fn3_c;
    logic [6:0]           fn7_c;
    logic [XLEN-1:0]      imm_c;
    logic                 illegal_c;

    logic                 in_ready_c;
    logic                 capture_c;

    logic                 out_valid_q;
    logic [XLEN-1:0]      pc_q;
    logic [6:0]           opcode_q;
    logic [RF_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [2:0]           fn3_q;
    logic [6:0]           fn7_q;
    logic [XLEN-1:0]      imm_q;
    logic                 illegal_q;

    rv_decode_comb #(
        .XLEN      (XLEN),
        .RF_ADDR_W (RF_ADDR_W),
        .EN_SYSTEM (EN_SYSTEM)
    ) u_dec (
        .inst      (bus.in_inst),
        .opcode_c  (opcode_c),
        .rd_c      (rd_c),
        .rs1_c     (rs1_c),
        .rs2_c     (rs2_c),
        .fn3_c     (fn3_c),
        .fn7_c     (fn7_c),
        .imm_c     (imm_c),
        .illegal_c (illegal_c)
    );

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign capture_c  = bus.in_valid && in_ready_c;

    // Flush wins over both a new capture and a held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= capture_c || (out_valid_q && !bus.out_ready);
        end
    end

    // Data may load under flush; out_valid alone decides whether it is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            fn3_q     <= '0;
            fn7_q     <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (capture_c) begin
            pc_q      <= bus.in_pc;
            opcode_q  <= opcode_c;
            rd_q      <= rd_c;
            rs1_q     <= rs1_c;
            rs2_q     <= rs2_c;
            fn3_q     <= fn3_c;
            fn7_q     <= fn7_c;
            imm_q     <= imm_c;
            illegal_q <= illegal_c;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.opcode    = opcode_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.fn3       = fn3_q;
    assign bus.fn7       = fn7_q;
    assign bus.imm       = imm_q;
    assign bus.illegal   = illegal_q;

endmodule
